// File: rtl/montgomery_constant_streamer.sv
`default_nettype none
// ============================================================================
// Module   : montgomery_constant_streamer
// Purpose  : Holds one multi-block Montgomery constant (N or k), loaded
//            serially, and streams it LSB block first. It advances on each
//            downstream consume and wraps to block 0 after the last block.
// Revision : 1.0 - initial release
// ============================================================================
module montgomery_constant_streamer #(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS    = 64
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [REGISTER_SIZE-1:0] load_block_in,
  input  logic                     load_valid_in,
  input  logic                     consumed_in,
  output logic [REGISTER_SIZE-1:0] block_out,
  output logic                     ready_out,
  output logic                     wrap_out,
  output logic                     underflow_error_out
);

  localparam int              PTR_W    = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_BLOCKS - 1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    SERVING = 2'd2
  } state_t;

  state_t                   state;
  logic [REGISTER_SIZE-1:0] mem [NUM_BLOCKS];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W-1:0]         rd_next;
  logic                     write_last;

  // Next read index wraps explicitly so non-power-of-two depths also work.
  assign rd_next    = (rd_ptr == LAST_IDX) ? '0 : rd_ptr + PTR_W'(1);
  // This write completes the constant. wr_ptr is 0 outside LOADING, so a
  // load from EMPTY or SERVING always restarts at block 0.
  assign write_last = load_valid_in && (wr_ptr == LAST_IDX);

  // Constant storage: not cleared by reset, written at the write pointer.
  always_ff @(posedge clk_in) begin
    if (!rst_in && load_valid_in) begin
      mem[wr_ptr] <= load_block_in;
    end
  end

  // Control FSM with registered outputs. A load takes priority over a consume.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state               <= EMPTY;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      block_out           <= '0;
      ready_out           <= 1'b0;
      wrap_out            <= 1'b0;
      underflow_error_out <= 1'b0;
    end else begin
      wrap_out <= 1'b0;

      // Consuming before the constant is complete is a sticky error. The
      // reload cycle is in SERVING, so it never raises the flag.
      if (consumed_in && (state != SERVING)) begin
        underflow_error_out <= 1'b1;
      end

      if (load_valid_in) begin
        rd_ptr <= '0;
        if (write_last) begin
          wr_ptr    <= '0;
          state     <= SERVING;
          ready_out <= 1'b1;
          // For a single block, mem[0] is being written on this same edge.
          block_out <= (NUM_BLOCKS == 1) ? load_block_in : mem[0];
        end else begin
          wr_ptr    <= wr_ptr + PTR_W'(1);
          state     <= LOADING;
          ready_out <= 1'b0;
        end
      end else if (consumed_in && (state == SERVING)) begin
        rd_ptr    <= rd_next;
        block_out <= mem[rd_next];
        wrap_out  <= (rd_ptr == LAST_IDX);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_montgomery_constant_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_montgomery_constant_streamer
// Purpose  : Self-checking bench for montgomery_constant_streamer with a
//            4-block instance (directed + random) and a 1-block instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_montgomery_constant_streamer;

  localparam int RS = 32;
  localparam int NB = 4;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  // 4-block instance signals
  logic          rst = 1'b1;
  logic [RS-1:0] load_block = '0;
  logic          load_valid = 1'b0;
  logic          consumed = 1'b0;
  logic [RS-1:0] block;
  logic          ready, wrap, uerr;

  // 1-block instance signals
  logic          rst1 = 1'b1;
  logic [RS-1:0] load_block1 = '0;
  logic          load_valid1 = 1'b0;
  logic          consumed1 = 1'b0;
  logic [RS-1:0] block1;
  logic          ready1, wrap1, uerr1;

  montgomery_constant_streamer #(.REGISTER_SIZE(RS), .NUM_BLOCKS(NB)) dut4 (
    .clk_in(clk), .rst_in(rst), .load_block_in(load_block),
    .load_valid_in(load_valid), .consumed_in(consumed),
    .block_out(block), .ready_out(ready), .wrap_out(wrap),
    .underflow_error_out(uerr)
  );

  montgomery_constant_streamer #(.REGISTER_SIZE(RS), .NUM_BLOCKS(1)) dut1 (
    .clk_in(clk), .rst_in(rst1), .load_block_in(load_block1),
    .load_valid_in(load_valid1), .consumed_in(consumed1),
    .block_out(block1), .ready_out(ready1), .wrap_out(wrap1),
    .underflow_error_out(uerr1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Single comparison point.
  task automatic check(input string tag, input logic [RS-1:0] got, input logic [RS-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the constant is a list of loaded words; serving is an
  // index into it taken modulo NB. Block value is only defined after reset
  // or when a full constant is available.
  logic [RS-1:0] m_words [NB];
  int            m_count   = 0;   // words of the constant being loaded
  bit            m_full    = 0;   // constant complete and being served
  int            m_idx     = 0;
  logic [RS-1:0] e_block   = '0;
  bit            e_known   = 1;
  bit            e_wrap    = 0;
  bit            e_err     = 0;
  int            wrap_seen = 0;

  task automatic model(input bit r, input bit lv, input logic [RS-1:0] d, input bit c);
    e_wrap = 0;
    if (r) begin
      m_count = 0; m_full = 0; m_idx = 0;
      e_block = '0; e_known = 1; e_err = 0;
    end else begin
      if (c && !m_full) e_err = 1;
      if (lv) begin
        if (m_full) m_count = 0;
        m_full  = 0;
        m_words[m_count] = d;
        m_count++;
        if (m_count == NB) begin
          m_count = 0; m_full = 1; m_idx = 0;
          e_block = m_words[0]; e_known = 1;
        end else begin
          e_known = 0;
        end
      end else if (c && m_full) begin
        m_idx   = (m_idx + 1) % NB;
        e_block = m_words[m_idx];
        e_wrap  = (m_idx == 0);
      end
    end
  endtask

  // One clock on the 4-block instance, then compare all outputs.
  task automatic step(input bit r, input bit lv, input logic [RS-1:0] d, input bit c);
    rst = r; load_valid = lv; load_block = d; consumed = c;
    @(posedge clk);
    model(r, lv, d, c);
    #1;
    check("ready", {31'b0, ready}, {31'b0, m_full});
    check("wrap",  {31'b0, wrap},  {31'b0, e_wrap});
    check("uerr",  {31'b0, uerr},  {31'b0, e_err});
    if (e_known) check("block", block, e_block);
    if (wrap) wrap_seen++;
  endtask

  initial begin
    // Reset
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Load and serve, then one full pass consuming every cycle
    step(0, 1, 32'h11, 0); step(0, 1, 32'h22, 0);
    step(0, 1, 32'h33, 0); step(0, 1, 32'h44, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Gapped reload and stalled consume
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 32'h11 * (i + 1), 0);
      step(0, 0, 0, 0);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
    end

    // Multi-pass: from index 0, 12 consumes give exactly 3 wraps
    step(0, 0, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 1); // back to index 0
    wrap_seen = 0;
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1);
    check("wrap_count", wrap_seen, 3);
    check("block_after_passes", block, 32'h11);

    // Underflow during loading, sticky across completion, cleared by reset
    step(1, 0, 0, 0);
    step(0, 1, 32'h11, 0); step(0, 1, 32'h22, 0);
    step(0, 0, 0, 1);
    step(0, 1, 32'h33, 0); step(0, 1, 32'h44, 0);
    check("uerr_sticky", {31'b0, uerr}, 32'd1);
    check("block_at_ready", block, 32'h11);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // Reload with concurrent consume at read index 2
    step(0, 1, 32'h11, 0); step(0, 1, 32'h22, 0);
    step(0, 1, 32'h33, 0); step(0, 1, 32'h44, 0);
    step(0, 0, 0, 1); step(0, 0, 0, 1);
    step(0, 1, 32'hA0, 1);
    step(0, 1, 32'hA1, 0); step(0, 1, 32'hA2, 0); step(0, 1, 32'hA3, 0);
    check("reload_block", block, 32'hA0);
    step(0, 0, 0, 1);

    // Reset mid-load, then full reload
    step(0, 1, 32'hB0, 0); step(0, 1, 32'hB1, 0);
    step(0, 1, 32'hB2, 0); step(0, 1, 32'hB3, 0);
    step(0, 1, 32'hC0, 0); step(0, 1, 32'hC1, 0);
    step(1, 1, 32'hC2, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 32'hD0 + i, 0);
    check("after_reset_reload", block, 32'hD0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 5) == 0),
           $urandom,
           ($urandom_range(0, 1) == 1));
    end

    // Single-block instance
    rst = 1'b1; load_valid = 1'b0; consumed = 1'b0;
    rst1 = 1'b1;
    @(posedge clk); #1;
    check("nb1_reset_ready", {31'b0, ready1}, 32'd0);
    check("nb1_reset_block", block1, 32'd0);
    rst1 = 1'b0; load_valid1 = 1'b1; load_block1 = 32'h5A5A1234;
    @(posedge clk); #1;
    load_valid1 = 1'b0;
    check("nb1_ready", {31'b0, ready1}, 32'd1);
    check("nb1_block", block1, 32'h5A5A1234);
    consumed1 = 1'b1;
    @(posedge clk); #1;
    consumed1 = 1'b0;
    check("nb1_wrap", {31'b0, wrap1}, 32'd1);
    check("nb1_block_wrap", block1, 32'h5A5A1234);
    check("nb1_no_err", {31'b0, uerr1}, 32'd0);
    @(posedge clk); #1;
    check("nb1_wrap_one_cycle", {31'b0, wrap1}, 32'd0);
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0; consumed1 = 1'b1;
    @(posedge clk); #1;
    consumed1 = 1'b0;
    check("nb1_underflow", {31'b0, uerr1}, 32'd1);
    check("nb1_underflow_ready", {31'b0, ready1}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
